// File: rtl/imem_responder_if.sv
// Fetch-side instruction memory read bus.
// The fetch stage is master; the memory responder is slave.
interface imem_rd_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               mem_rd_enable;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               mem_rd_ready;
  logic [INSTR_W-1:0] mem_rd_data;
  logic               mem_rd_error;

  modport master (
    output mem_rd_enable,
    output mem_rd_addr,
    input  mem_rd_ready,
    input  mem_rd_data,
    input  mem_rd_error
  );

  modport slave (
    input  mem_rd_enable,
    input  mem_rd_addr,
    output mem_rd_ready,
    output mem_rd_data,
    output mem_rd_error
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction RAM answering one fetch read at a time after a fixed latency,
// with a side port for preloading program words.
module imem_responder #(
  parameter int                 LATENCY   = 1,
  parameter int                 DEPTH     = 256,
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [INSTR_W-1:0] FILL_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_rd_if.slave                 rd,
  output logic                     busy,
  input  logic                     ld_enable,
  input  logic [$clog2(DEPTH)-1:0] ld_index,
  input  logic [INSTR_W-1:0]       ld_data
);
  localparam int IW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("imem_responder: LATENCY must be 1..15");
  end
  if (DEPTH < 2 || (1 << IW) != DEPTH) begin : g_depth_chk
    $error("imem_responder: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  off;
  logic [IW-1:0]      idx;
  logic               bad;
  logic [INSTR_W-1:0] mem [DEPTH];

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign off = req_addr - BASE_ADDR;
  assign idx = off[IW+1:2];
  assign bad = (|off[1:0]) | (|off[ADDR_W-1:IW+2]);

  always_ff @(posedge clk) begin
    if (ld_enable)
      mem[ld_index] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      busy            <= 1'b0;
      rd.mem_rd_ready <= 1'b0;
      rd.mem_rd_data  <= '0;
      rd.mem_rd_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd.mem_rd_enable) begin
            req_addr <= rd.mem_rd_addr;
            cnt      <= 4'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rd.mem_rd_ready <= 1'b1;
            rd.mem_rd_data  <= bad ? FILL_WORD : mem[idx];
            rd.mem_rd_error <= bad;
            state           <= RESP;
          end
        end
        RESP: begin
          rd.mem_rd_ready <= 1'b0;
          rd.mem_rd_error <= 1'b0;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the slave end of the fetch stage's memory read interface (mem_rd_enable / mem_rd_addr / mem_rd_ready / mem_rd_data).
- Holds a word array, accepts one read request at a time and returns the word after a fixed, parameterised latency with a one-cycle ready strobe.
- Has a side load port so benches and boot logic can preload program words.
- Replaces ad-hoc memory models in simulation and serves as the on-chip instruction RAM.

Parameters:
- LATENCY, 1, cycles from request-accept edge to the edge that raises mem_rd_ready. Legal range 1..15. 0 is illegal and is rejected at elaboration.
- DEPTH, 256, number of 32-bit words. Must be a power of two.
- BASE_ADDR, 32'h0, byte address of word 0.
- FILL_WORD, 32'h00000013, data returned for out-of-range or misaligned reads (NOP).

Ports:
- clk  in  1  clock; everything is posedge.
- reset  in  1  synchronous, active-high.
- mem_rd_enable  in  1  read request from fetch.
- mem_rd_addr  in  `ADDR_SIZE+1  byte address of the request.
- mem_rd_ready  out  1  one-cycle strobe: mem_rd_data is valid.
- mem_rd_data  out  `INSTR_SIZE+1  returned instruction word.
- mem_rd_error  out  1  pulses with mem_rd_ready when the response used FILL_WORD.
- busy  out  1  high while a request is outstanding (WAIT or RESP).
- ld_enable  in  1  preload write strobe.
- ld_index  in  log2(DEPTH)  word index to write.
- ld_data  in  `INSTR_SIZE+1  word to write.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, mem_rd_ready=0, mem_rd_data=0, mem_rd_error=0, busy=0, counter=0. The array contents are NOT cleared.
- Reset mid-operation: any outstanding request is dropped and no ready is produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_rd_enable=1 at a posedge: latch mem_rd_addr into req_addr, load counter=LATENCY-1, go to WAIT, busy=1.
  - If mem_rd_enable=0: stay in IDLE.
- WAIT:
  - counter!=0: decrement.
  - counter==0 at a posedge: drive mem_rd_ready=1, mem_rd_data=word, mem_rd_error=flag, go to RESP.
  - mem_rd_enable is ignored in WAIT. Deasserting it does not cancel the request, which always completes.
  - Changes on mem_rd_addr while in WAIT are ignored; req_addr is used.
- RESP:
  - mem_rd_ready=0 and mem_rd_error=0 at the next posedge, go to IDLE.
  - mem_rd_enable is ignored in RESP.
  - Minimum request spacing is therefore LATENCY+2 cycles.
- Latency: for an accept edge at cycle N, mem_rd_ready is high during cycle N+LATENCY, exactly one cycle wide.
- mem_rd_data holds its last value after ready drops, until the next response or reset.
- Address decode (req_addr):
  - off = req_addr - BASE_ADDR, truncated to address width.
  - Misaligned: off[1:0]!=0.
  - Out of range: off>>2 >= DEPTH, including the case where req_addr < BASE_ADDR wraps to a large off.
  - Either condition returns FILL_WORD with mem_rd_error=1.
  - Otherwise the response is array[off>>2].
- Load port:
  - ld_enable=1 at a posedge writes array[ld_index]=ld_data.
  - It is independent of the FSM and is allowed during reset.
- Same-edge collision: a load to the word being read on the response edge returns the OLD contents; the new value is visible to later reads.

Test Plan:
- Reset then preload: write index 0..3 = 32'h8000..32'h8003, LATENCY=1. Pulse mem_rd_enable with addr=0 -> ready high exactly one cycle, 1 cycle after the accept edge, data=32'h8000, error=0.
- LATENCY=3, addr=8: mem_rd_ready rises on the 3rd edge after accept; data=32'h8002. Drop enable in WAIT -> the response still arrives. busy is high from accept through RESP.
- Out-of-range and misaligned checks:
  - addr=DEPTH*4=1024 -> data=32'h00000013, error=1 for one cycle.
  - addr=2 -> FILL_WORD, error=1.
  - BASE_ADDR=32'h100 with addr=32'hFC -> FILL_WORD (wrap case).
- Enable held high continuously, addr 0 then 4: two responses exactly LATENCY+2 cycles apart; no extra or missing ready.
- Reset during WAIT (LATENCY=4, reset asserted 2 cycles after accept): no ready ever appears; outputs are 0 the cycle after the reset edge. The array still returns 32'h8001 for addr=4 afterwards.
- Collision: ld_index=1, ld_data=32'hDEAD on the response edge of a read of addr=4 -> returns 32'h8001; the next read of addr=4 returns 32'hDEAD.
